// File: rtl/sap1_pkg.sv
//------------------------------------------------------------------------------
// Module   : sap1_pkg
// Brief    : Shared SAP-1 constants: opcodes, control-bit indices, control words
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sap1_pkg;

  localparam int T_STATES = 6;
  localparam int CON_W    = 12;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int CON_CP  = 11;
  localparam int CON_EP  = 10;
  localparam int CON_NLM = 9;
  localparam int CON_NCE = 8;
  localparam int CON_NLI = 7;
  localparam int CON_NEI = 6;
  localparam int CON_NLA = 5;
  localparam int CON_EA  = 4;
  localparam int CON_SU  = 3;
  localparam int CON_EU  = 2;
  localparam int CON_NLB = 1;
  localparam int CON_NLO = 0;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

  localparam logic [T_STATES-1:0] T1_ONEHOT = 6'b000001;

  // Each word is the idle word with the named bits toggled to their active level.
  localparam logic [CON_W-1:0] CON_ONE     = 12'h001;
  localparam logic [CON_W-1:0] CON_IDLE    = 12'h3E3;
  localparam logic [CON_W-1:0] CON_T1      = CON_IDLE ^ (CON_ONE << CON_EP)  ^ (CON_ONE << CON_NLM);
  localparam logic [CON_W-1:0] CON_T2      = CON_IDLE ^ (CON_ONE << CON_CP);
  localparam logic [CON_W-1:0] CON_T3      = CON_IDLE ^ (CON_ONE << CON_NCE) ^ (CON_ONE << CON_NLI);
  localparam logic [CON_W-1:0] CON_ADDR_T4 = CON_IDLE ^ (CON_ONE << CON_NEI) ^ (CON_ONE << CON_NLM);
  localparam logic [CON_W-1:0] CON_LDA_T5  = CON_IDLE ^ (CON_ONE << CON_NCE) ^ (CON_ONE << CON_NLA);
  localparam logic [CON_W-1:0] CON_ADD_T5  = CON_IDLE ^ (CON_ONE << CON_NCE) ^ (CON_ONE << CON_NLB);
  localparam logic [CON_W-1:0] CON_ADD_T6  = CON_IDLE ^ (CON_ONE << CON_EU)  ^ (CON_ONE << CON_NLA);
  localparam logic [CON_W-1:0] CON_SUB_T6  = CON_ADD_T6 ^ (CON_ONE << CON_SU);
  localparam logic [CON_W-1:0] CON_OUT_T4  = CON_IDLE ^ (CON_ONE << CON_EA)  ^ (CON_ONE << CON_NLO);

  typedef enum logic [0:0] {
    RUN_S  = 1'b0,
    HALT_S = 1'b1
  } run_state_e;

endpackage

`default_nettype wire

// File: rtl/ring_counter.sv
//------------------------------------------------------------------------------
// Module   : ring_counter
// Brief    : One-hot T-state ring counter with hold and restart-to-T1 controls
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ring_counter
  import sap1_pkg::*;
(
  input  logic                CLK,
  input  logic                CLR,
  input  logic                hold,
  input  logic                restart,
  output logic [T_STATES-1:0] tstate
);

  logic [T_STATES-1:0] r_tstate;

  // hold outranks restart so a halted machine never slips back to T1
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_tstate <= T1_ONEHOT;
    end else if (hold) begin
      r_tstate <= r_tstate;
    end else if (restart) begin
      r_tstate <= T1_ONEHOT;
    end else begin
      r_tstate <= {r_tstate[T_STATES-2:0], r_tstate[T_STATES-1]};
    end
  end

  assign tstate = r_tstate;

endmodule

`default_nettype wire

// File: rtl/controller_sequencer.sv
//------------------------------------------------------------------------------
// Module   : controller_sequencer
// Brief    : SAP-1 control unit; decodes opcode and T-state into the control word.
//            Optional macro CTRL_SKIP_NOP_EN shortens cycles past the last active state.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module controller_sequencer
  import sap1_pkg::*;
(
  input  logic                CLK,
  input  logic                CLR,
  input  logic [3:0]          opcode,
  output logic [CON_W-1:0]    con,
  output logic [T_STATES-1:0] tstate,
  output logic                HLT
);

  run_state_e       r_state;
  logic             w_halt_now;
  logic             w_hold;
  logic             w_restart;
  logic [CON_W-1:0] w_con;

  assign w_halt_now = tstate[T4_IDX] && (opcode == OP_HLT);
  assign w_hold     = (r_state == HALT_S) || w_halt_now;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= RUN_S;
    end else begin
      case (r_state)
        RUN_S:   if (w_halt_now) r_state <= HALT_S;
        HALT_S:  r_state <= HALT_S;
        default: r_state <= RUN_S;
      endcase
    end
  end

`ifdef CTRL_SKIP_NOP_EN
  always_comb begin
    w_restart = 1'b0;
    if (tstate[T5_IDX] && (opcode == OP_LDA)) begin
      w_restart = 1'b1;
    end
    if (tstate[T4_IDX] && (opcode != OP_LDA) && (opcode != OP_ADD) &&
        (opcode != OP_SUB) && (opcode != OP_HLT)) begin
      w_restart = 1'b1;
    end
  end
`else
  assign w_restart = 1'b0;
`endif

  ring_counter u_ring_counter (
    .CLK     (CLK),
    .CLR     (CLR),
    .hold    (w_hold),
    .restart (w_restart),
    .tstate  (tstate)
  );

  // Opcode is only consulted from T4 on, so fetch words are immune to IR churn.
  always_comb begin
    w_con = CON_IDLE;
    if (r_state == RUN_S) begin
      if (tstate[T1_IDX]) begin
        w_con = CON_T1;
      end else if (tstate[T2_IDX]) begin
        w_con = CON_T2;
      end else if (tstate[T3_IDX]) begin
        w_con = CON_T3;
      end else if (tstate[T4_IDX]) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: w_con = CON_ADDR_T4;
          OP_OUT:                 w_con = CON_OUT_T4;
          default:                w_con = CON_IDLE;
        endcase
      end else if (tstate[T5_IDX]) begin
        case (opcode)
          OP_LDA:         w_con = CON_LDA_T5;
          OP_ADD, OP_SUB: w_con = CON_ADD_T5;
          default:        w_con = CON_IDLE;
        endcase
      end else if (tstate[T6_IDX]) begin
        case (opcode)
          OP_ADD:  w_con = CON_ADD_T6;
          OP_SUB:  w_con = CON_SUB_T6;
          default: w_con = CON_IDLE;
        endcase
      end
    end
  end

  assign con = w_con;
  assign HLT = w_hold;

endmodule

`default_nettype wire

// File: tb/tb_controller_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_controller_sequencer
// Brief    : Directed self-checking bench for controller_sequencer
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_controller_sequencer;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  tstate;
  logic        HLT;

  int tests = 0;
  int fails = 0;

`ifdef CTRL_SKIP_NOP_EN
  localparam int LEN_LDA   = 5;
  localparam int LEN_SHORT = 4;
`else
  localparam int LEN_LDA   = 6;
  localparam int LEN_SHORT = 6;
`endif
  localparam int LEN_ARITH = 6;

  controller_sequencer dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .opcode (opcode),
    .con    (con),
    .tstate (tstate),
    .HLT    (HLT)
  );

  always #5 CLK = ~CLK;

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] t_exp,
                     input logic [11:0] c_exp, input logic h_exp);
    tests++;
    assert (tstate === t_exp) else begin
      fails++;
      $error("FAIL %s tstate=%b expected %b", tag, tstate, t_exp);
    end
    tests++;
    assert (con === c_exp) else begin
      fails++;
      $error("FAIL %s con=%h expected %h", tag, con, c_exp);
    end
    tests++;
    assert (HLT === h_exp) else begin
      fails++;
      $error("FAIL %s HLT=%b expected %b", tag, HLT, h_exp);
    end
  endtask

  // Starts in T1, holds fop through T1-T3, presents op for execute, ends in T4.
  task automatic fetch(input string tag, input logic [3:0] fop, input logic [3:0] op);
    opcode = fop;
    chk({tag, " T1"}, 6'b000001, 12'h5E3, 1'b0);
    adv();
    chk({tag, " T2"}, 6'b000010, 12'hBE3, 1'b0);
    adv();
    chk({tag, " T3"}, 6'b000100, 12'h263, 1'b0);
    opcode = op;
    adv();
  endtask

  task automatic run_instr(input string tag, input logic [3:0] fop, input logic [3:0] op,
                           input int len, input logic [11:0] e4, input logic [11:0] e5,
                           input logic [11:0] e6);
    fetch(tag, fop, op);
    chk({tag, " T4"}, 6'b001000, e4, 1'b0);
    adv();
    if (len >= 5) begin
      chk({tag, " T5"}, 6'b010000, e5, 1'b0);
      adv();
    end
    if (len >= 6) begin
      chk({tag, " T6"}, 6'b100000, e6, 1'b0);
      adv();
    end
  endtask

  initial begin
    CLR    = 1'b1;
    opcode = 4'hx;
    adv();
    adv();
    chk("reset", 6'b000001, 12'h5E3, 1'b0);
    CLR = 1'b0;

    run_instr("lda0", 4'hx, 4'b0000, LEN_LDA,   12'h1A3, 12'h2C3, 12'h3E3);
    run_instr("add",  4'hF, 4'b0001, LEN_ARITH, 12'h1A3, 12'h2E1, 12'h3C7);
    run_instr("sub",  4'hF, 4'b0010, LEN_ARITH, 12'h1A3, 12'h2E1, 12'h3CF);
    run_instr("out",  4'h0, 4'b1110, LEN_SHORT, 12'h3F2, 12'h3E3, 12'h3E3);
    run_instr("nop5", 4'hF, 4'b0101, LEN_SHORT, 12'h3E3, 12'h3E3, 12'h3E3);
    run_instr("nopD", 4'h1, 4'b1101, LEN_SHORT, 12'h3E3, 12'h3E3, 12'h3E3);
    run_instr("lda1", 4'hF, 4'b0000, LEN_LDA,   12'h1A3, 12'h2C3, 12'h3E3);

    fetch("halt", 4'h2, 4'b1111);
    chk("halt T4", 6'b001000, 12'h3E3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      adv();
      opcode = 4'(i);
      chk("halted", 6'b001000, 12'h3E3, 1'b1);
    end
    CLR = 1'b1;
    adv();
    CLR = 1'b0;
    chk("unhalt", 6'b000001, 12'h5E3, 1'b0);
    adv();
    chk("unhalt T2", 6'b000010, 12'hBE3, 1'b0);
    adv();
    adv();
    adv();
    adv();
    adv();
    chk("post-halt wrap", 6'b000001, 12'h5E3, 1'b0);

    fetch("mid", 4'hF, 4'b0001);
    chk("mid T4", 6'b001000, 12'h1A3, 1'b0);
    adv();
    chk("mid T5", 6'b010000, 12'h2E1, 1'b0);
    CLR = 1'b1;
    adv();
    CLR = 1'b0;
    chk("mid reset", 6'b000001, 12'h5E3, 1'b0);
    adv();
    chk("mid reset T2", 6'b000010, 12'hBE3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
